multicycle_control_fsm: RTL and testbench
=========================================

# multicycle_control_fsm

Main control state machine for the multicycle processor. It sequences each instruction through fetch, decode, execute, memory and writeback. Each cycle it drives the datapath strobes and mux selects, and it supplies the 4-bit opcode consumed by the ALU. It reads back the ALU zero flag to resolve BEQ and stalls on a memory-ready handshake.

## Interface

Parameters:
- MUL_CYCLES, 3, number of cycles EXECUTE holds for a multiply (legal 1..15)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset (synchronous, active-high)
- instr_op  in  6  instruction bits [31:26], valid from DECODE onward (IR output)
- funct  in  6  instruction bits [5:0]
- zero_flag  in  1  ALU zero flag, meaningful while alu_op=0001
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  PC load enable
- ir_write  out  1  instruction register load enable
- iord  out  1  memory address select: 0=PC, 1=ALUOut
- mem_write  out  1  memory write strobe
- reg_write  out  1  register file write enable
- mem_to_reg  out  1  writeback data select: 0=ALUOut, 1=MDR
- reg_dst  out  1  destination register select: 0=rt, 1=rd
- alu_src_a  out  1  ALU A select: 0=PC, 1=A register
- alu_src_b  out  2  ALU B select: 00=B register, 01=constant 4, 10=sign-extended imm, 11=sign-extended imm<<2
- pc_src  out  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target
- alu_op  out  4  ALU opcode: 0000 add, 0001 sub, 0010 mul, 0011 and, 0100 or
- state_out  out  4  current state encoding (debug)
- illegal  out  1  sticky illegal-instruction flag

## Operation

- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, TRAP=12.
- Output defaults: any output not listed for a state is 0.
- FETCH
  - Drives iord=0, alu_src_a=0, alu_src_b=01, alu_op=0000, pc_src=00.
  - ir_write=pc_write=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE
  - Drives alu_src_a=0, alu_src_b=11, alu_op=0000 (branch target into ALUOut).
  - Dispatch on instr_op:
    - 000000 → EXECUTE
    - 100011 (LW) or 101011 (SW) → MEMADR
    - 000100 (BEQ) → BRANCH
    - 001000 (ADDI) → ADDIEX
    - 000010 (J) → JUMP
    - any other op → TRAP
  - R-type funct is also checked here. Legal values are 100000, 100010, 011000, 100100, 100101; any other funct → TRAP.
- MEMADR: drives alu_src_a=1, alu_src_b=10, alu_op=0000. Goes to MEMRD for LW, MEMWR for SW.
- MEMRD: drives iord=1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: drives reg_write=1, mem_to_reg=1, reg_dst=0. Goes to FETCH.
- MEMWR: drives iord=1, mem_write=1. mem_write stays asserted until the mem_ready cycle, then the FSM goes to FETCH.
- EXECUTE
  - Drives alu_src_a=1, alu_src_b=00.
  - funct to alu_op: 100000→0000, 100010→0001, 011000→0010, 100100→0011, 100101→0100.
  - Multiply holds EXECUTE for MUL_CYCLES cycles using a 4-bit counter: cleared on entry, increments each cycle, exits when count=MUL_CYCLES-1.
  - Other functions exit after 1 cycle. Exit goes to ALUWB.
- ALUWB: drives reg_write=1, reg_dst=1, mem_to_reg=0. Goes to FETCH.
- BRANCH: drives alu_src_a=1, alu_src_b=00, alu_op=0001, pc_src=01, pc_write=zero_flag (the only Mealy output). Goes to FETCH.
- ADDIEX: drives alu_src_a=1, alu_src_b=10, alu_op=0000. Goes to ADDIWB.
- ADDIWB: drives reg_write=1, reg_dst=0, mem_to_reg=0. Goes to FETCH.
- JUMP: drives pc_src=10, pc_write=1. Goes to FETCH.
- TRAP: sets illegal=1, drives no strobes, and stays in TRAP until reset.

## Timing

- Reset, sampled on the rising edge of clk:
  - State becomes FETCH, the multiply counter 0, illegal 0.
  - While rst=1, every output is forced to 0 and state_out reads 0.
- Outputs are decoded from the registered state; pc_write in BRANCH is additionally combinational in zero_flag.
- Instruction latency with mem_ready tied to 1, counted in cycles from FETCH through the last state inclusive:
  - BEQ: 3
  - J: 3
  - R-type (non-mul): 4
  - ADDI: 4
  - SW: 4
  - LW: 5
  - mul: 3+MUL_CYCLES
- Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle. Strobes other than ir_write and pc_write hold steady during the stall.
- Reset asserted mid-instruction aborts it. No reg_write or mem_write is asserted in the reset cycle or in the cycle after.
- zero_flag is sampled only in BRANCH; its value in any other state is ignored.

## Test plan

- rst=1 for 2 cycles, then released with mem_ready=1 → every output is 0 during reset; state_out is 0, then 1, on the next two cycles.
- R-type add (op 000000, funct 100000) → state sequence 0,1,6,7,0; alu_op=0000 in EXECUTE; reg_write=1 and reg_dst=1 only in ALUWB.
- mul with MUL_CYCLES=3 (funct 011000) → EXECUTE held exactly 3 cycles with alu_op=0010; total 6 cycles to return to FETCH.
- LW with mem_ready low for 2 cycles in MEMRD → sequence 0,1,2,3,3,3,4,0; mem_to_reg=1 and reg_write=1 only in MEMWB.
- BEQ run twice, with zero_flag=1 and then zero_flag=0 in BRANCH → pc_write=1 with pc_src=01 in the first run; pc_write=0 in the second.
- op 111111 → TRAP (12) after DECODE; illegal=1 and no strobes until rst; after rst, illegal=0 and state is FETCH.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
//   Main control sequencer of the multicycle processor. Walks every
//   instruction through fetch, decode, execute, memory and writeback,
//   decoding datapath strobes, mux selects and the 4-bit ALU opcode from
//   the registered state.
//
//   Handshake: mem_ready is a single-cycle completion signal. While the
//   FSM sits in FETCH, MEMRD or MEMWR it holds its request and all selects
//   steady; the cycle in which mem_ready=1 is the cycle the access
//   completes, and the FSM advances on the following clock edge.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   instr_op, funct        instruction fields from the IR
//   zero_flag              ALU zero flag (used only in BRANCH)
//   mem_ready              memory access completes this cycle
//   pc_write .. alu_op     datapath controls
//   state_out              current state encoding (debug)
//   illegal                sticky illegal-instruction flag
module multicycle_control_fsm #(
  parameter int MUL_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] instr_op,
  input  logic [5:0] funct,
  input  logic       zero_flag,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_write,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [3:0] alu_op,
  output logic [3:0] state_out,
  output logic       illegal
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11,
    TRAP    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [3:0] MUL_LAST = 4'(MUL_CYCLES - 1);

  state_t     state, next_state;
  logic [3:0] mul_cnt, mul_cnt_next;
  logic       illegal_q;

  logic       funct_legal;
  logic       is_mul;
  logic [3:0] funct_alu_op;

  // R-type function decode shared by DECODE (legality) and EXECUTE (opcode).
  always_comb begin
    funct_legal  = 1'b1;
    funct_alu_op = 4'b0000;
    case (funct)
      6'b100000: funct_alu_op = 4'b0000;
      6'b100010: funct_alu_op = 4'b0001;
      6'b011000: funct_alu_op = 4'b0010;
      6'b100100: funct_alu_op = 4'b0011;
      6'b100101: funct_alu_op = 4'b0100;
      default:   funct_legal  = 1'b0;
    endcase
  end

  assign is_mul = (funct == 6'b011000);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      mul_cnt   <= 4'd0;
      illegal_q <= 1'b0;
    end else begin
      state   <= next_state;
      mul_cnt <= mul_cnt_next;
      if (next_state == TRAP) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    next_state   = state;
    mul_cnt_next = mul_cnt;
    pc_write     = 1'b0;
    ir_write     = 1'b0;
    iord         = 1'b0;
    mem_write    = 1'b0;
    reg_write    = 1'b0;
    mem_to_reg   = 1'b0;
    reg_dst      = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'b00;
    pc_src       = 2'b00;
    alu_op       = 4'b0000;

    case (state)
      FETCH: begin
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) next_state = DECODE;
      end
      DECODE: begin
        alu_src_b    = 2'b11;
        mul_cnt_next = 4'd0;
        case (instr_op)
          OP_RTYPE:     next_state = funct_legal ? EXECUTE : TRAP;
          OP_LW, OP_SW: next_state = MEMADR;
          OP_BEQ:       next_state = BRANCH;
          OP_ADDI:      next_state = ADDIEX;
          OP_J:         next_state = JUMP;
          default:      next_state = TRAP;
        endcase
      end
      MEMADR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        next_state = (instr_op == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        iord = 1'b1;
        if (mem_ready) next_state = MEMWB;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        next_state = FETCH;
      end
      MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) next_state = FETCH;
      end
      EXECUTE: begin
        alu_src_a    = 1'b1;
        alu_op       = funct_alu_op;
        mul_cnt_next = mul_cnt + 4'd1;
        // Multiply holds here until the counter reaches MUL_CYCLES-1.
        if (!is_mul || mul_cnt == MUL_LAST) next_state = ALUWB;
      end
      ALUWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        next_state = FETCH;
      end
      BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = 4'b0001;
        pc_src     = 2'b01;
        pc_write   = zero_flag;
        next_state = FETCH;
      end
      ADDIEX: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        next_state = ADDIWB;
      end
      ADDIWB: begin
        reg_write  = 1'b1;
        next_state = FETCH;
      end
      JUMP: begin
        pc_src     = 2'b10;
        pc_write   = 1'b1;
        next_state = FETCH;
      end
      TRAP:    next_state = TRAP;
      default: next_state = FETCH;
    endcase

    // Reset silences the datapath in the very cycle it is asserted.
    if (rst) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      iord       = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      reg_dst    = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      pc_src     = 2'b00;
      alu_op     = 4'b0000;
    end
  end

  assign state_out = rst ? 4'd0 : state;
  assign illegal   = illegal_q & ~rst;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm
//   Builds a cycle-by-cycle plan from whole instructions (kind, stall
//   counts, branch outcome), expanding each into its expected phase list,
//   then drives the plan and compares every output each cycle.
module tb_multicycle_control_fsm;
  localparam int MUL_CYCLES = 3;
  localparam int W = 21;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3,
                 S_MEMWB = 4, S_MEMWR = 5, S_EXECUTE = 6, S_ALUWB = 7,
                 S_BRANCH = 8, S_ADDIEX = 9, S_ADDIWB = 10, S_JUMP = 11,
                 S_TRAP = 12;

  // Index in this table is the ALU opcode for that funct.
  localparam logic [5:0] FN_TAB [5] = '{6'b100000, 6'b100010, 6'b011000,
                                        6'b100100, 6'b100101};

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic [5:0] instr_op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero_flag = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, ir_write, iord, mem_write, reg_write, mem_to_reg;
  logic       reg_dst, alu_src_a, illegal;
  logic [1:0] alu_src_b, pc_src;
  logic [3:0] alu_op, state_out;

  multicycle_control_fsm #(.MUL_CYCLES(MUL_CYCLES)) dut (
    .clk(clk), .rst(rst), .instr_op(instr_op), .funct(funct),
    .zero_flag(zero_flag), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .iord(iord),
    .mem_write(mem_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .reg_dst(reg_dst), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_src(pc_src), .alu_op(alu_op), .state_out(state_out),
    .illegal(illegal)
  );

  logic [W-1:0] obs;
  assign obs = {state_out, illegal, pc_write, ir_write, iord, mem_write,
                reg_write, mem_to_reg, reg_dst, alu_src_a, alu_src_b,
                pc_src, alu_op};

  typedef struct packed {
    logic       r;
    logic       mr;
    logic       zf;
    logic [5:0] op;
    logic [5:0] fn;
  } stim_t;

  stim_t        stim_q[$];
  logic [W-1:0] exp_q[$];
  int           seen_q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  logic         running = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, req);
    end
  endtask

  // Expected outputs of one phase, straight from the per-state output list.
  function automatic logic [W-1:0] model_out(input int st, input logic mr,
                                             input logic zf,
                                             input logic [5:0] fn);
    logic ill, pcw, irw, io, mw, rw, m2r, rd, asa;
    logic [1:0] asb, pcs;
    logic [3:0] aop;
    {ill, pcw, irw, io, mw, rw, m2r, rd, asa} = '0;
    asb = 2'b00; pcs = 2'b00; aop = 4'b0000;
    case (st)
      S_FETCH:   begin asb = 2'b01; irw = mr; pcw = mr; end
      S_DECODE:  asb = 2'b11;
      S_MEMADR:  begin asa = 1; asb = 2'b10; end
      S_MEMRD:   io = 1;
      S_MEMWB:   begin rw = 1; m2r = 1; end
      S_MEMWR:   begin io = 1; mw = 1; end
      S_EXECUTE: begin
        asa = 1;
        for (int i = 0; i < 5; i++) if (FN_TAB[i] == fn) aop = 4'(i);
      end
      S_ALUWB:   begin rw = 1; rd = 1; end
      S_BRANCH:  begin asa = 1; aop = 4'b0001; pcs = 2'b01; pcw = zf; end
      S_ADDIEX:  begin asa = 1; asb = 2'b10; end
      S_ADDIWB:  rw = 1;
      S_JUMP:    begin pcs = 2'b10; pcw = 1; end
      S_TRAP:    ill = 1;
      default:   ;
    endcase
    return {4'(st), ill, pcw, irw, io, mw, rw, m2r, rd, asa, asb, pcs, aop};
  endfunction

  // driver tasks: plan building
  task automatic add_row(input int st, input logic mr, input logic zf,
                         input logic [5:0] op, input logic [5:0] fn);
    stim_t s;
    s.r = 1'b0; s.mr = mr; s.zf = zf; s.op = op; s.fn = fn;
    stim_q.push_back(s);
    exp_q.push_back(model_out(st, mr, zf, fn));
  endtask

  task automatic add_reset();
    stim_t s;
    s.r = 1'b1; s.mr = 1'($urandom_range(0, 1)); s.zf = 1'($urandom_range(0, 1));
    s.op = 6'($urandom_range(0, 63)); s.fn = 6'($urandom_range(0, 63));
    stim_q.push_back(s);
    exp_q.push_back('0);
  endtask

  function automatic logic op_known(input logic [5:0] op);
    return op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
           op == 6'b000100 || op == 6'b001000 || op == 6'b000010;
  endfunction

  function automatic logic fn_known(input logic [5:0] fn);
    logic k = 1'b0;
    for (int i = 0; i < 5; i++) if (FN_TAB[i] == fn) k = 1'b1;
    return k;
  endfunction

  // kind: 0..4 R-type (FN_TAB index), 5 LW, 6 SW, 7 BEQ, 8 ADDI, 9 J,
  //       10 op 111111, 11 random unknown op, 12 R-type unknown funct.
  // cut>0 aborts the instruction with a reset after that many cycles.
  task automatic add_instr(input int kind, input int fstall, input int mstall,
                           input logic zf_br, input int cut);
    logic [5:0] op, fn;
    int start;
    bit trap;
    start = exp_q.size();
    fn = 6'($urandom_range(0, 63));
    trap = 0;
    case (kind)
      0, 1, 2, 3, 4: begin op = 6'b000000; fn = FN_TAB[kind]; end
      5:  op = 6'b100011;
      6:  op = 6'b101011;
      7:  op = 6'b000100;
      8:  op = 6'b001000;
      9:  op = 6'b000010;
      10: op = 6'b111111;
      11: begin
        op = 6'($urandom_range(0, 63));
        while (op_known(op)) op = 6'($urandom_range(0, 63));
      end
      default: begin
        op = 6'b000000;
        while (fn_known(fn)) fn = 6'($urandom_range(0, 63));
      end
    endcase
    for (int i = 0; i < fstall; i++)
      add_row(S_FETCH, 1'b0, 1'($urandom_range(0, 1)), op, fn);
    add_row(S_FETCH, 1'b1, 1'($urandom_range(0, 1)), op, fn);
    add_row(S_DECODE, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), op, fn);
    case (kind)
      0, 1, 2, 3, 4: begin
        for (int i = 0; i < ((kind == 2) ? MUL_CYCLES : 1); i++)
          add_row(S_EXECUTE, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), op, fn);
        add_row(S_ALUWB, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), op, fn);
      end
      5, 6: begin
        add_row(S_MEMADR, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), op, fn);
        for (int i = 0; i < mstall; i++)
          add_row(kind == 5 ? S_MEMRD : S_MEMWR, 1'b0, 1'($urandom_range(0, 1)), op, fn);
        add_row(kind == 5 ? S_MEMRD : S_MEMWR, 1'b1, 1'($urandom_range(0, 1)), op, fn);
        if (kind == 5)
          add_row(S_MEMWB, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), op, fn);
      end
      7: add_row(S_BRANCH, 1'($urandom_range(0, 1)), zf_br, op, fn);
      8: begin
        add_row(S_ADDIEX, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), op, fn);
        add_row(S_ADDIWB, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), op, fn);
      end
      9: add_row(S_JUMP, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), op, fn);
      default: begin
        trap = 1;
        for (int i = 0; i < 3; i++)
          add_row(S_TRAP, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), op, fn);
      end
    endcase
    if (cut > 0) begin
      while (exp_q.size() > start + cut) begin
        void'(exp_q.pop_back());
        void'(stim_q.pop_back());
      end
      add_reset();
    end else if (trap) begin
      add_reset();
      add_reset();
    end
  endtask

  // scoreboard: one comparison per cycle against the plan
  always @(negedge clk) begin
    if (running && exp_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      check($sformatf("cycle%0d", cyc), obs, e);
      seen_q.push_back(int'(state_out));
      cyc++;
    end
  end

  int n0, len_add, len_mul, len_lw;
  initial begin
    // directed section
    add_reset();
    add_reset();
    n0 = exp_q.size(); add_instr(0, 0, 0, 1'b0, 0); len_add = exp_q.size() - n0;
    n0 = exp_q.size(); add_instr(2, 0, 0, 1'b0, 0); len_mul = exp_q.size() - n0;
    n0 = exp_q.size(); add_instr(5, 0, 2, 1'b0, 0); len_lw  = exp_q.size() - n0;
    add_instr(7, 0, 0, 1'b1, 0);
    add_instr(7, 0, 0, 1'b0, 0);
    add_instr(10, 1, 0, 1'b0, 0);
    add_instr(6, 2, 3, 1'b0, 0);
    add_instr(5, 0, 2, 1'b0, 4);
    add_instr(6, 0, 2, 1'b0, 4);
    add_instr(12, 0, 0, 1'b0, 0);
    // randomized section
    for (int i = 0; i < 200; i++) begin
      int k;
      k = ($urandom_range(0, 19) == 0) ? $urandom_range(10, 12) : $urandom_range(0, 9);
      add_instr(k, $urandom_range(0, 2), $urandom_range(0, 2),
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 15) == 0) ? $urandom_range(1, 3) : 0);
    end

    // pin the model against hand-derived values
    check("len_add", W'(len_add), W'(4));
    check("len_mul", W'(len_mul), W'(3 + MUL_CYCLES));
    check("len_lw", W'(len_lw), W'(7));
    check("model_branch_taken", model_out(S_BRANCH, 1'b0, 1'b1, 6'd0),
          21'b1000_0_1_0_0_0_0_0_0_1_00_01_0001);
    check("model_fetch", model_out(S_FETCH, 1'b1, 1'b0, 6'd0),
          21'b0000_0_1_1_0_0_0_0_0_0_01_00_0000);
    check("model_exec_mul", model_out(S_EXECUTE, 1'b0, 1'b0, 6'b011000),
          21'b0110_0_0_0_0_0_0_0_0_1_00_00_0010);

    while (stim_q.size() > 0) begin
      stim_t s;
      s = stim_q.pop_front();
      @(posedge clk);
      #1;
      rst = s.r; mem_ready = s.mr; zero_flag = s.zf;
      instr_op = s.op; funct = s.fn;
      running = 1'b1;
    end
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected cycles left, required 0", exp_q.size());
    end

    // literal state trace of reset release, add, then start of mul
    if (seen_q.size() >= 7) begin
      check("st_rst0", W'(seen_q[0]), W'(0));
      check("st_rst1", W'(seen_q[1]), W'(0));
      check("st_fetch", W'(seen_q[2]), W'(0));
      check("st_decode", W'(seen_q[3]), W'(1));
      check("st_execute", W'(seen_q[4]), W'(6));
      check("st_aluwb", W'(seen_q[5]), W'(7));
      check("st_next_fetch", W'(seen_q[6]), W'(0));
    end else begin
      errors++;
      $display("FAIL trace_len: got %0d required >=7", seen_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
